// File: rtl/boot_loader.sv
// boot_loader: fills the 2048 x 16 instruction RAM from a UART byte frame
// (LEN_HI LEN_LO {HI LO}*N CHK), holding the CPU in reset until the frame is
// accepted, then steers the CPU pc onto the instruction-memory address port.
// Latency: one WRITE cycle per word after its low byte; RUN begins the cycle
// after the CHK byte is accepted; mem_addr follows pc combinationally in RUN.
// Backpressure: rx_ready drops during WRITE/RUN/ERR, so the source holds its byte.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   rx_data/valid/ready   - byte stream from uart_rx (transfer on valid && ready)
//   pc                    - CPU program counter (low AW bits used in RUN)
//   mem_addr/wdata/we     - instruction RAM write/address port
//   cpu_reset             - holds the CPU in reset until RUN
//   boot_done/boot_error  - frame accepted / frame rejected (terminal)
module boot_loader #(
  parameter int DEPTH   = 2048,
  parameter int AW      = 11,
  parameter int TIMEOUT = 25_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [15:0]   pc,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          mem_we,
  output logic          cpu_reset,
  output logic          boot_done,
  output logic          boot_error
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DAT_HI = 3'd2;
  localparam logic [2:0] S_DAT_LO = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_SUM    = 3'd5;
  localparam logic [2:0] S_RUN    = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [15:0]   len;
  logic [15:0]   wdata;
  logic [7:0]    sum;
  logic [TW-1:0] tcnt;

  logic          accept;
  logic          timed;
  logic [15:0]   len_rx;
  logic [15:0]   idx_p1;
  logic          unused_pc;

  assign accept    = rx_valid && rx_ready;
  assign len_rx    = {len[15:8], rx_data};
  // Index + 1 compared against N avoids a separate N-1 register.
  assign idx_p1    = 16'(idx) + 16'd1;
  assign unused_pc = ^pc[15:AW];

  // States in which an idle clock counts toward the inter-byte timeout.
  always_comb begin
    timed = 1'b0;
    case (state)
      S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_SUM: timed = 1'b1;
      default: timed = 1'b0;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_SUM: rx_ready = !reset;
      default: rx_ready = 1'b0;
    endcase
  end

  assign mem_addr   = (state == S_RUN) ? pc[AW-1:0] : idx;
  assign mem_wdata  = wdata;
  assign mem_we     = (state == S_WRITE) && !reset;
  assign cpu_reset  = (state != S_RUN) || reset;
  assign boot_done  = (state == S_RUN) && !reset;
  assign boot_error = (state == S_ERR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LEN_HI;
      idx   <= '0;
      len   <= '0;
      wdata <= '0;
      sum   <= '0;
      tcnt  <= '0;
    end else begin
      // The CHK byte itself is not folded into the running sum.
      if (accept && state != S_SUM) sum <= sum + rx_data;

      case (state)
        S_LEN_HI: if (accept) begin
          len   <= {rx_data, 8'h00};
          state <= S_LEN_LO;
        end
        S_LEN_LO: if (accept) begin
          len   <= len_rx;
          state <= (len_rx == 16'd0 || len_rx > DEPTH16) ? S_ERR : S_DAT_HI;
        end
        S_DAT_HI: if (accept) begin
          wdata[15:8] <= rx_data;
          state       <= S_DAT_LO;
        end
        S_DAT_LO: if (accept) begin
          wdata[7:0] <= rx_data;
          state      <= S_WRITE;
        end
        S_WRITE: begin
          if (idx_p1 == len) begin
            state <= S_SUM;
          end else begin
            idx   <= idx + AW'(1);
            state <= S_DAT_HI;
          end
        end
        S_SUM: if (accept) state <= (rx_data == sum) ? S_RUN : S_ERR;
        default: ;
      endcase

      // Placed after the case so an expiring timeout overrides any transition.
      if (accept || state == S_LEN_HI) begin
        tcnt <= '0;
      end else if (timed) begin
        if (tcnt == TMAX) state <= S_ERR;
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] pc = 16'h0000;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_reset;
  logic        boot_done;
  logic        boot_error;

  int vectors = 0;
  int miscompares = 0;

  boot_loader #(.DEPTH(2048), .AW(11), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cpu_reset(cpu_reset), .boot_done(boot_done),
    .boot_error(boot_error)
  );

  always #5 clk = ~clk;

  // Observed traffic, captured from the DUT's pins.
  logic [26:0] wr_q[$];
  logic [7:0]  acc_q[$];
  logic [15:0] tb_mem [0:2047];
  int          ready_in_write = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      tb_mem[mem_addr] = mem_wdata;
      if (rx_ready) ready_in_write++;
    end
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
  end

  // Frame under test and the reference model's predictions.
  logic [7:0]  frame_q[$];
  logic [26:0] exp_wr_q[$];
  int          exp_consumed;
  int          exp_outcome; // 1 = loaded and running, 2 = rejected

  task automatic model_frame();
    int n, s;
    exp_wr_q.delete();
    n = int'(frame_q[0]) * 256 + int'(frame_q[1]);
    if (n == 0 || n > 2048) begin
      exp_consumed = 2;
      exp_outcome  = 2;
    end else begin
      for (int i = 0; i < n; i++)
        exp_wr_q.push_back({11'(i), frame_q[2 + 2 * i], frame_q[3 + 2 * i]});
      s = 0;
      for (int j = 0; j < 2 + 2 * n; j++) s += int'(frame_q[j]);
      s = s % 256;
      exp_consumed = 2 * n + 3;
      exp_outcome  = (int'(frame_q[2 + 2 * n]) == s) ? 1 : 2;
    end
  endtask

  task automatic make_frame(input int n, input bit good);
    int s;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(n / 256));
    frame_q.push_back(8'(n % 256));
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      frame_q.push_back(b);
    end
    s = 0;
    foreach (frame_q[k]) s += int'(frame_q[k]);
    if (!good) s += 1 + int'($urandom_range(0, 254));
    frame_q.push_back(8'(s % 256));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_q.delete();
    acc_q.delete();
    ready_in_write = 0;
  endtask

  // Presents one byte after `gap` idle cycles and returns on the negedge
  // following the accepting clock edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (!rx_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte: rx_ready=%0b for byte %02h after %0d cycles, required 1", rx_ready, b, waited);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input int max_gap);
    int bad, n0;
    model_frame();
    for (int i = 0; i < exp_consumed; i++)
      send_byte(frame_q[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));

    vectors++;
    if (boot_done !== (exp_outcome == 1) || boot_error !== (exp_outcome == 2) ||
        cpu_reset !== (exp_outcome != 1) || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s final: done=%0b err=%0b cpu_rst=%0b rdy=%0b, required outcome %0d", name,
               boot_done, boot_error, cpu_reset, rx_ready, exp_outcome);
    end

    vectors++;
    bad = (acc_q.size() != exp_consumed) ? 0 : -1;
    if (bad < 0) foreach (acc_q[k]) if (bad < 0 && acc_q[k] !== frame_q[k]) bad = k;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s accepted bytes: got %0d bytes, required %0d (first diff %0d)", name,
               acc_q.size(), exp_consumed, bad);
    end

    vectors++;
    if (wr_q.size() != exp_wr_q.size()) begin
      miscompares++;
      $display("FAIL %s write count: %0d, required %0d", name, wr_q.size(), exp_wr_q.size());
    end else begin
      foreach (exp_wr_q[k]) begin
        vectors++;
        if (wr_q[k] !== exp_wr_q[k]) begin
          miscompares++;
          $display("FAIL %s write %0d: addr %03h data %04h, required addr %03h data %04h", name, k,
                   wr_q[k][26:16], wr_q[k][15:0], exp_wr_q[k][26:16], exp_wr_q[k][15:0]);
        end
      end
    end

    vectors++;
    if (ready_in_write !== 0) begin
      miscompares++;
      $display("FAIL %s ready in write: %0d cycles with rx_ready=1, required 0", name, ready_in_write);
    end

    // Once terminal, further bytes must be refused.
    n0 = acc_q.size();
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (acc_q.size() != n0 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post-frame byte: accepted %0d extra, rdy=%0b, required 0 and 0", name,
               acc_q.size() - n0, rx_ready);
    end
    rx_valid = 1'b0;
  endtask

  task automatic load_happy(input logic [7:0] chk);
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, chk};
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b0 || mem_we !== 1'b0 || cpu_reset !== 1'b1 ||
        boot_done !== 1'b0 || boot_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset hold: rdy=%0b we=%0b cpu_rst=%0b done=%0b err=%0b, required 0 0 1 0 0",
               rx_ready, mem_we, cpu_reset, boot_done, boot_error);
    end
    rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b1 || cpu_reset !== 1'b1 || boot_done !== 1'b0 ||
        boot_error !== 1'b0 || mem_addr !== 11'h000) begin
      miscompares++;
      $display("FAIL reset release: rdy=%0b cpu_rst=%0b done=%0b err=%0b addr=%03h, required 1 1 0 0 000",
               rx_ready, cpu_reset, boot_done, boot_error, mem_addr);
    end
  endtask

  task automatic test_happy();
    do_reset();
    load_happy(8'hC0);
    run_frame("happy", 0);
    pc = 16'h0805;
    #1;
    vectors++;
    if (mem_addr !== 11'h005) begin
      miscompares++;
      $display("FAIL happy pc route: mem_addr=%03h, required 005", mem_addr);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    load_happy(8'hC1);
    run_frame("bad_chk", 0);
  endtask

  task automatic test_length_bounds();
    do_reset();
    frame_q = '{8'h08, 8'h01};
    run_frame("len_2049", 0);
    do_reset();
    frame_q = '{8'h00, 8'h00};
    run_frame("len_0", 0);
  endtask

  task automatic test_full_depth();
    do_reset();
    make_frame(2048, 1'b1);
    run_frame("len_2048", 0);
    vectors++;
    if (wr_q.size() == 0 || wr_q[wr_q.size() - 1][26:16] !== 11'h7FF) begin
      miscompares++;
      $display("FAIL len_2048 last addr: writes=%0d, required last addr 7ff", wr_q.size());
    end
  endtask

  task automatic test_timeout();
    int k;
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    k = 0;
    while (!boot_error && k < 3 * TMO) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k !== TMO || cpu_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: error after %0d clocks (cpu_rst=%0b), required %0d", k, cpu_reset, TMO);
    end
    do_reset();
    repeat (1000) @(negedge clk);
    vectors++;
    if (boot_error !== 1'b0 || rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle len_hi: err=%0b rdy=%0b, required 0 1", boot_error, rx_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    do_reset();
    frame_q = '{8'h00, 8'h01, 8'hFF, 8'hEE, 8'hEE};
    run_frame("mid_reset", 0);
    vectors++;
    if (tb_mem[0] !== 16'hFFEE) begin
      miscompares++;
      $display("FAIL mid_reset mem0: %04h, required ffee", tb_mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] p;
    do_reset();
    load_happy(8'hC0);
    run_frame("gapped_happy", 20);
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 8));
      do_reset();
      make_frame(n, t % 3 != 2);
      run_frame("random_frame", 20);
      if (exp_outcome == 1) begin
        p  = 16'($urandom_range(0, 65535));
        pc = p;
        #1;
        vectors++;
        if (int'(mem_addr) !== int'(p) % 2048) begin
          miscompares++;
          $display("FAIL random pc route: pc=%04h mem_addr=%03h", p, mem_addr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_bad_checksum();
    test_length_bounds();
    test_full_depth();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
